// File: rtl/offload_stream_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// offload_pkg
//   Shared definitions for the offload stream arbiter slice:
//     PKT_MAGIC       - marker expected in the top word of a packet's first beat
//     REG_SIZE        - width of the marker word
//     DEFAULT_DATA_W  - default tdata width of the arbiter
//     state_t         - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package offload_pkg;

    localparam int REG_SIZE       = 32;
    localparam int DEFAULT_DATA_W = 512;

    localparam logic [REG_SIZE-1:0] PKT_MAGIC = 32'h0FFA_0FFB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

endpackage

// File: rtl/offload_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// offload_stream_arbiter_if
//   Bundles the NUM_REQ upstream AXI-Stream requesters (s_axis_*, packed,
//   requester r in slice r) and the single downstream stream (m_axis_*).
//   Modports:
//     slave  - the arbiter's view (consumes s_axis, produces m_axis)
//     master - the environment's view (produces s_axis, consumes m_axis)
// ---------------------------------------------------------------------------
interface offload_stream_arbiter_if
    import offload_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEFAULT_DATA_W
);
    localparam int KEEP_W = DATA_W / 8;

    logic [NUM_REQ-1:0]        s_axis_tvalid;
    logic [NUM_REQ-1:0]        s_axis_tready;
    logic [NUM_REQ-1:0]        s_axis_tlast;
    logic [NUM_REQ*DATA_W-1:0] s_axis_tdata;
    logic [NUM_REQ*KEEP_W-1:0] s_axis_tkeep;

    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;

    modport slave (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        output m_axis_tready
    );

endinterface

// File: rtl/offload_stream_arbiter_rr.sv
// ---------------------------------------------------------------------------
// offload_rr_arbiter
//   Combinational round-robin priority selector. Search starts at
//   (last_grant+1) mod NUM_REQ and wraps.
//   Ports:
//     req        in  NUM_REQ  request vector
//     last_grant in  IDX_W    index granted most recently
//     grant      out IDX_W    selected index (0 when nothing requests)
//     any_req    out 1        at least one request is active
// ---------------------------------------------------------------------------
module offload_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest
    // active requester after last_grant is the one that sticks.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_W'((32'(last_grant) + 32'(i)) % 32'(NUM_REQ));
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/offload_stream_arbiter.sv
// ---------------------------------------------------------------------------
// offload_stream_arbiter
//   Packet-locked round-robin arbiter merging NUM_REQ AXI-Stream requesters
//   into one stream toward the offload engine.
//   Ports:
//     clk        in   sole clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     bus        if   offload_stream_arbiter_if.slave (s_axis_* / m_axis_*)
//     grant_id   out  index of the locked requester (registered)
//     busy       out  high while a packet is locked (PASS or DROP)
//     dbg        out  {sticky protocol error, DROP, PASS, IDLE}
//     drop_count out  16-bit saturating dropped-packet count (filter build only)
//   Build option:
//     OFFLOAD_ARB_MAGIC_FILTER_EN - when defined, a packet whose first beat
//     lacks PKT_MAGIC in its top word or has partial tkeep is consumed and
//     discarded (DROP state) instead of forwarded.
//
//   Handshake: a beat moves on any stream only in a cycle where tvalid and
//   tready are both high; a source holding tvalid must keep it and its data
//   stable until that happens. tready here never depends on a requester's
//   own tvalid, only on state, grant and m_axis_tready.
// ---------------------------------------------------------------------------
module offload_stream_arbiter
    import offload_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DEFAULT_DATA_W,
    localparam int KEEP_W  = DATA_W / 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    offload_stream_arbiter_if.slave    bus,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       busy,
    output logic [3:0]                 dbg
`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    // Requester 0 must win the first arbitration after reset.
    localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_REQ - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, last_grant_q, rr_grant;
    logic             rr_any;
    logic             stall_q, err_q;
    logic             g_valid, g_last, pass_last, pkt_done;

    logic [DATA_W-1:0] req_data [NUM_REQ];
    logic [KEEP_W-1:0] req_keep [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign req_data[r] = bus.s_axis_tdata[r*DATA_W +: DATA_W];
        assign req_keep[r] = bus.s_axis_tkeep[r*KEEP_W +: KEEP_W];
    end

    offload_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (bus.s_axis_tvalid),
        .last_grant (last_grant_q),
        .grant      (rr_grant),
        .any_req    (rr_any)
    );

    assign g_valid   = bus.s_axis_tvalid[grant_q];
    assign g_last    = bus.s_axis_tlast[grant_q];
    assign pass_last = (state_q == ST_PASS) && g_valid && bus.m_axis_tready && g_last;

`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
    logic        first_ok, drop_last;
    logic [15:0] drop_cnt_q;

    // Judged on the beat the round-robin winner presents while still in IDLE.
    assign first_ok   = (req_data[rr_grant][DATA_W-1 -: REG_SIZE] == PKT_MAGIC) &&
                        (&req_keep[rr_grant]);
    // In DROP tready is forced high, so valid & last completes the packet.
    assign drop_last  = (state_q == ST_DROP) && g_valid && g_last;
    assign pkt_done   = pass_last || drop_last;
    assign drop_count = drop_cnt_q;
`else
    assign pkt_done = pass_last;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
                    state_d = first_ok ? ST_PASS : ST_DROP;
`else
                    state_d = ST_PASS;
`endif
                end
            end
            ST_PASS: begin
                if (pass_last) state_d = ST_IDLE;
            end
`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
            ST_DROP: begin
                if (drop_last) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: IDLE drives everything to zero; PASS is a pure
    // combinational mirror of the locked requester.
    always_comb begin
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tkeep  = '0;
        bus.s_axis_tready = '0;
        busy              = (state_q != ST_IDLE);
        grant_id          = grant_q;
        dbg               = {err_q, 1'b0, (state_q == ST_PASS), (state_q == ST_IDLE)};
        unique case (state_q)
            ST_PASS: begin
                bus.m_axis_tvalid          = g_valid;
                bus.m_axis_tlast           = g_last;
                bus.m_axis_tdata           = req_data[grant_q];
                bus.m_axis_tkeep           = req_keep[grant_q];
                bus.s_axis_tready[grant_q] = bus.m_axis_tready;
            end
`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
            ST_DROP: begin
                bus.s_axis_tready[grant_q] = 1'b1;
                dbg[2]                     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Grant lock and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            if (state_q == ST_IDLE && rr_any) grant_q <= rr_grant;
            if (pkt_done) last_grant_q <= grant_q;
        end
    end

    // Sticky protocol error: the locked requester withdrew tvalid in the
    // cycle right after it was stalled (valid high, downstream not ready).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= (state_q == ST_PASS) && g_valid && !bus.m_axis_tready;
            if (stall_q && (state_q == ST_PASS) && !g_valid) err_q <= 1'b1;
        end
    end

`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (state_q == ST_IDLE && rr_any && !first_ok && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_offload_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_offload_stream_arbiter
//   Directed bench for offload_stream_arbiter (NUM_REQ=4, DATA_W=64).
//   Per-requester beat queues feed a driver; expected output beats are
//   queued in exp_q and a monitor compares every m_axis transfer.
// ---------------------------------------------------------------------------
module tb_offload_stream_arbiter;
  import offload_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int IDX_W   = 2;
  localparam int BEAT_W  = 1 + KEEP_W + DATA_W;
  localparam int EXP_W   = IDX_W + BEAT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  offload_stream_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

  logic [IDX_W-1:0] grant_id;
  logic             busy;
  logic [3:0]       dbg;
`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
  logic [15:0]      drop_count;
`endif

  offload_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .dbg      (dbg)
`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
    ,
    .drop_count (drop_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [BEAT_W-1:0] rq [NUM_REQ][$];
  logic [EXP_W-1:0]  exp_q[$];
  int                xfer_cyc[$];
  logic [NUM_REQ-1:0] hold_low = '0;
  logic m_rdy = 1'b1;
  logic tog_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    logic [BEAT_W-1:0] beat;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rq[r].size() > 0 && !hold_low[r]) begin
        beat = rq[r][0];
        bus.s_axis_tvalid[r] = 1'b1;
        bus.s_axis_tlast[r]  = beat[BEAT_W-1];
        bus.s_axis_tkeep[r*KEEP_W +: KEEP_W] = beat[DATA_W +: KEEP_W];
        bus.s_axis_tdata[r*DATA_W +: DATA_W] = beat[DATA_W-1:0];
      end else begin
        bus.s_axis_tvalid[r] = 1'b0;
        bus.s_axis_tlast[r]  = 1'b0;
        bus.s_axis_tkeep[r*KEEP_W +: KEEP_W] = '0;
        bus.s_axis_tdata[r*DATA_W +: DATA_W] = '0;
      end
    end
    bus.m_axis_tready = m_rdy;
  endtask

  initial begin
    logic [NUM_REQ-1:0] hs;
    drive_inputs();
    forever begin
      @(negedge clk);
      hs = bus.s_axis_tvalid & bus.s_axis_tready;
      if (!reset_n) hs = '0;
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++)
        if (hs[r] && rq[r].size() > 0) void'(rq[r].pop_front());
      if (tog_en) m_rdy = ~m_rdy;
      drive_inputs();
    end
  end

  task automatic push_pkt(input int r, input int n, input int tag, input logic expect_out);
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
    for (int b = 0; b < n; b++) begin
      d = {PKT_MAGIC, 32'(tag * 16 + b)};
      k = (b == n - 1 && n > 1) ? 8'h0F : 8'hFF;
      l = (b == n - 1);
      rq[r].push_back({l, k, d});
      if (expect_out) exp_q.push_back({IDX_W'(r), l, k, d});
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [NUM_REQ-1:0] allowed;
    logic               stalled;
    logic [BEAT_W-1:0]  held;
    logic [EXP_W-1:0]   e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        allowed = (dbg[1] || dbg[2]) ? (NUM_REQ'(1) << grant_id) : '0;
        check("tready_mask", bus.s_axis_tready & ~allowed, 0);
        if (dbg[0])
          check("idle_outputs", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, 0);
        if (stalled && bus.m_axis_tvalid)
          check("stall_hold", {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, held);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            e = exp_q.pop_front();
            check("beat", {grant_id, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, e);
          end
          xfer_cyc.push_back(cyc);
        end
        stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
        held = {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic rq_empty();
    for (int r = 0; r < NUM_REQ; r++) if (rq[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0) && rq_empty() && dbg[0];
    end
    if (!done) fail_now({name, "_timeout"});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
    exp_q.delete();
    hold_low = '0;
    tog_en = 1'b0;
    m_rdy = 1'b1;
    drive_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int rise_cyc;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dbg", dbg, 4'b0001);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_m_tvalid", bus.m_axis_tvalid, 0);
    check("rst_s_tready", bus.s_axis_tready, 0);
`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
    check("rst_drop_count", drop_count, 0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester 1, 3 beats, ready high
    xfer_cyc.delete();
    push_pkt(1, 3, 1, 1'b1);
    seen = 1'b0;
    rise_cyc = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus.s_axis_tvalid[1]) begin
        seen = 1'b1;
        rise_cyc = cyc;
        check("t1_idle_on_rise", dbg, 4'b0001);
      end
    end
    if (!seen) fail_now("t1_tvalid_timeout");
    wait_idle("t1", 40);
    check("t1_xfers", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      check("t1_latency", xfer_cyc[0] - rise_cyc, 1);
      check("t1_back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);
    end
    check("t1_grant", grant_id, 1);
    check("t1_idle", dbg, 4'b0001);

    // All four requesters, one-beat packets: order 0,1,2,3,0
    do_reset();
    xfer_cyc.delete();
    push_pkt(0, 1, 10, 1'b1);
    push_pkt(1, 1, 11, 1'b1);
    push_pkt(2, 1, 12, 1'b1);
    push_pkt(3, 1, 13, 1'b1);
    push_pkt(0, 1, 14, 1'b1);
    wait_idle("t2", 60);
    check("t2_xfers", xfer_cyc.size(), 5);
    if (xfer_cyc.size() == 5)
      for (int i = 1; i < 5; i++) check("t2_gap", xfer_cyc[i] - xfer_cyc[i-1], 2);

    // Requester 2 four beats with toggling ready; requester 0 held meanwhile
    @(negedge clk);
    xfer_cyc.delete();
    push_pkt(2, 4, 20, 1'b1);
    push_pkt(0, 1, 21, 1'b1);
    tog_en = 1'b1;
    wait_idle("t3", 80);
    tog_en = 1'b0;
    m_rdy = 1'b1;
    check("t3_xfers", xfer_cyc.size(), 5);
    check("t3_grant_last", grant_id, 0);

    // Reset during beat 2 of 5
    do_reset();
    @(negedge clk);
    xfer_cyc.delete();
    push_pkt(1, 5, 30, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = (xfer_cyc.size() >= 1);
    end
    if (!seen) fail_now("t4_first_beat_timeout");
    check("t4_midpkt_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t4_rst_dbg", dbg, 4'b0001);
    check("t4_rst_grant", grant_id, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_m_tvalid", bus.m_axis_tvalid, 0);
    check("t4_rst_m_tdata", bus.m_axis_tdata, 0);
    check("t4_rst_s_tready", bus.s_axis_tready, 0);
    for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
    exp_q.delete();
    drive_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_pkt(0, 1, 32, 1'b1);
    push_pkt(3, 1, 33, 1'b1);
    wait_idle("t4", 40);
    check("t4_grant_after", grant_id, 3);

    // Protocol error: tvalid withdrawn while stalled
    @(negedge clk);
    m_rdy = 1'b0;
    push_pkt(1, 2, 40, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = dbg[1];
    end
    if (!seen) fail_now("t5_pass_timeout");
    check("t5_no_err_yet", dbg[3], 0);
    hold_low[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_err_set", dbg[3], 1);
    check("t5_m_tvalid_low", bus.m_axis_tvalid, 0);
    check("t5_lock_busy", busy, 1);
    check("t5_lock_grant", grant_id, 1);
    hold_low[1] = 1'b0;
    m_rdy = 1'b1;
    wait_idle("t5", 40);
    check("t5_err_sticky", dbg, 4'b1001);
    do_reset();
    check("t5_err_cleared", dbg, 4'b0001);

`ifdef OFFLOAD_ARB_MAGIC_FILTER_EN
    // Bad magic on requester 3 is consumed and counted, then a good packet passes
    @(negedge clk);
    check("t6_count0", drop_count, 0);
    rq[3].push_back({1'b0, 8'hFF, 32'hDEAD_BEEF, 32'h0000_0001});
    rq[3].push_back({1'b1, 8'hFF, 32'hDEAD_BEEF, 32'h0000_0002});
    wait_idle("t6_drop", 40);
    check("t6_count1", drop_count, 1);
    push_pkt(3, 2, 50, 1'b1);
    wait_idle("t6_pass", 40);
    check("t6_count_kept", drop_count, 1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
